// File: rtl/axi_sram_slave.sv
// AXI3 slave fronting a word-addressed 32-bit SRAM.
// Independent read and write engines, one outstanding burst each.
module axi_sram_slave #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  io_arid,
    input  logic [31:0] io_araddr,
    input  logic [7:0]  io_arlen,
    input  logic [2:0]  io_arsize,
    input  logic [1:0]  io_arburst,
    input  logic        io_arvalid,
    output logic        io_arready,
    output logic [3:0]  io_rid,
    output logic [31:0] io_rdata,
    output logic [1:0]  io_rresp,
    output logic        io_rlast,
    output logic        io_rvalid,
    input  logic        io_rready,
    input  logic [3:0]  io_awid,
    input  logic [31:0] io_awaddr,
    input  logic [7:0]  io_awlen,
    input  logic [2:0]  io_awsize,
    input  logic [1:0]  io_awburst,
    input  logic        io_awvalid,
    output logic        io_awready,
    input  logic [3:0]  io_wid,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    input  logic        io_wlast,
    input  logic        io_wvalid,
    output logic        io_wready,
    output logic [3:0]  io_bid,
    output logic [1:0]  io_bresp,
    output logic        io_bvalid,
    input  logic        io_bready
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        R_IDLE,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef struct packed {
        logic       err;
        logic [3:0] len;
        logic [1:0] size;
        logic [1:0] burst;
    } req_t;

    // Illegal encodings are flagged and then served as the nearest legal burst
    function automatic req_t decode_req(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        req_t r;
        logic wrap_ok;
        wrap_ok = (len[3:0] == 4'd1) || (len[3:0] == 4'd3) ||
                  (len[3:0] == 4'd7) || (len[3:0] == 4'd15);
        r.len   = len[3:0];
        r.size  = (size > 3'd2) ? 2'd2 : size[1:0];
        r.burst = burst;
        r.err   = (len[7:4] != 4'd0) || (size > 3'd2);
        if (burst == 2'b11) begin
            r.burst = BURST_INCR;
            r.err   = 1'b1;
        end else if (burst == BURST_WRAP && !wrap_ok) begin
            r.burst = BURST_INCR;
            r.err   = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] next_addr(
        input logic [31:0] addr,
        input logic [3:0]  len,
        input logic [1:0]  size,
        input logic [1:0]  burst
    );
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] nxt;
        step = 32'd1 << size;
        mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_WRAP:  nxt = (addr & ~mask) | ((addr + step) & mask);
            default:     nxt = addr + step;
        endcase
        return nxt;
    endfunction

    logic [31:0] mem [2**ADDR_BITS];

    req_t ar_req;
    req_t aw_req;

    assign ar_req = decode_req(io_arlen, io_arsize, io_arburst);
    assign aw_req = decode_req(io_awlen, io_awsize, io_awburst);

    // ---------------- read engine ----------------

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_id_q, r_id_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [3:0]  r_len_q, r_len_d;
    logic [1:0]  r_size_q, r_size_d;
    logic [1:0]  r_burst_q, r_burst_d;
    logic        r_err_q, r_err_d;
    logic [3:0]  r_beat_q, r_beat_d;
    logic        r_last;

    assign r_last = (r_beat_q == r_len_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (io_arvalid) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (io_rready && r_last) begin
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_err_d   = r_err_q;
        r_beat_d  = r_beat_q;
        if (r_state_q == R_IDLE && io_arvalid) begin
            r_id_d    = io_arid;
            r_addr_d  = io_araddr;
            r_len_d   = ar_req.len;
            r_size_d  = ar_req.size;
            r_burst_d = ar_req.burst;
            r_err_d   = ar_req.err;
            r_beat_d  = 4'd0;
        end else if (r_state_q == R_DATA && io_rready) begin
            r_beat_d = r_beat_q + 4'd1;
            r_addr_d = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_id_q    <= 4'd0;
            r_addr_q  <= 32'd0;
            r_len_q   <= 4'd0;
            r_size_q  <= 2'd0;
            r_burst_q <= BURST_FIXED;
            r_err_q   <= 1'b0;
            r_beat_q  <= 4'd0;
        end else begin
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
            r_beat_q  <= r_beat_d;
        end
    end

    always_comb begin
        io_arready = (r_state_q == R_IDLE);
        io_rvalid  = (r_state_q == R_DATA);
        io_rlast   = (r_state_q == R_DATA) && r_last;
        io_rid     = r_id_q;
        io_rresp   = (r_state_q == R_DATA && r_err_q) ? RESP_SLVERR : RESP_OKAY;
        io_rdata   = mem[r_addr_q[ADDR_BITS+1:2]];
    end

    // ---------------- write engine ----------------

    w_state_e    w_state_q, w_state_d;
    logic [3:0]  w_id_q, w_id_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [3:0]  w_len_q, w_len_d;
    logic [1:0]  w_size_q, w_size_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic        w_err_q, w_err_d;
    logic [3:0]  w_beat_q, w_beat_d;
    logic        w_beat_last;
    logic        mem_we;

    assign w_beat_last = (w_beat_q == w_len_q);
    assign mem_we      = (w_state_q == W_DATA) && io_wvalid;

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (io_awvalid) begin
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (io_wvalid && (io_wlast || w_beat_last)) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (io_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        w_beat_d  = w_beat_q;
        if (w_state_q == W_IDLE && io_awvalid) begin
            w_id_d    = io_awid;
            w_addr_d  = io_awaddr;
            w_len_d   = aw_req.len;
            w_size_d  = aw_req.size;
            w_burst_d = aw_req.burst;
            w_err_d   = aw_req.err;
            w_beat_d  = 4'd0;
        end else if (mem_we) begin
            // Early wlast or a missing wlast on the final beat
            w_err_d  = w_err_q | (io_wlast != w_beat_last);
            w_beat_d = w_beat_q + 4'd1;
            w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_id_q    <= 4'd0;
            w_addr_q  <= 32'd0;
            w_len_q   <= 4'd0;
            w_size_q  <= 2'd0;
            w_burst_q <= BURST_FIXED;
            w_err_q   <= 1'b0;
            w_beat_q  <= 4'd0;
        end else begin
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            w_beat_q  <= w_beat_d;
        end
    end

    always_comb begin
        io_awready = (w_state_q == W_IDLE);
        io_wready  = (w_state_q == W_DATA);
        io_bvalid  = (w_state_q == W_RESP);
        io_bid     = w_id_q;
        io_bresp   = (w_state_q == W_RESP && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    end

    // Contents survive reset; reads see pre-edge data on a same-cycle write
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (io_wstrb[i]) begin
                    mem[w_addr_q[ADDR_BITS+1:2]][i*8 +: 8] <= io_wdata[i*8 +: 8];
                end
            end
        end
    end

    logic unused_wid;
    assign unused_wid = ^io_wid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_axi_sram_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  io_arid;
    logic [31:0] io_araddr;
    logic [7:0]  io_arlen;
    logic [2:0]  io_arsize;
    logic [1:0]  io_arburst;
    logic        io_arvalid;
    logic        io_arready;
    logic [3:0]  io_rid;
    logic [31:0] io_rdata;
    logic [1:0]  io_rresp;
    logic        io_rlast;
    logic        io_rvalid;
    logic        io_rready;
    logic [3:0]  io_awid;
    logic [31:0] io_awaddr;
    logic [7:0]  io_awlen;
    logic [2:0]  io_awsize;
    logic [1:0]  io_awburst;
    logic        io_awvalid;
    logic        io_awready;
    logic [3:0]  io_wid;
    logic [31:0] io_wdata;
    logic [3:0]  io_wstrb;
    logic        io_wlast;
    logic        io_wvalid;
    logic        io_wready;
    logic [3:0]  io_bid;
    logic [1:0]  io_bresp;
    logic        io_bvalid;
    logic        io_bready;

    int errors = 0;
    int checks = 0;

    logic [31:0] wq [16];
    logic [1:0]  wr_bresp;
    logic [3:0]  wr_bid;
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id;
    logic        rd_first;
    int          rd_n;

    always #5 clock = ~clock;

    axi_sram_slave #(.ADDR_BITS(12)) dut (
        .clock(clock), .reset(reset),
        .io_arid(io_arid), .io_araddr(io_araddr), .io_arlen(io_arlen),
        .io_arsize(io_arsize), .io_arburst(io_arburst),
        .io_arvalid(io_arvalid), .io_arready(io_arready),
        .io_rid(io_rid), .io_rdata(io_rdata), .io_rresp(io_rresp),
        .io_rlast(io_rlast), .io_rvalid(io_rvalid), .io_rready(io_rready),
        .io_awid(io_awid), .io_awaddr(io_awaddr), .io_awlen(io_awlen),
        .io_awsize(io_awsize), .io_awburst(io_awburst),
        .io_awvalid(io_awvalid), .io_awready(io_awready),
        .io_wid(io_wid), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
        .io_wlast(io_wlast), .io_wvalid(io_wvalid), .io_wready(io_wready),
        .io_bid(io_bid), .io_bresp(io_bresp),
        .io_bvalid(io_bvalid), .io_bready(io_bready)
    );

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input int nbeats, input logic [3:0] strb);
        int t;
        bit to;
        to = 0;
        @(negedge clock);
        io_awid = id; io_awaddr = addr; io_awlen = len;
        io_awsize = 3'd2; io_awburst = burst; io_awvalid = 1'b1;
        t = 0;
        while (!io_awready && t < 50) begin @(negedge clock); t++; end
        if (t >= 50) to = 1;
        @(negedge clock);
        io_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            io_wvalid = 1'b1; io_wdata = wq[i]; io_wstrb = strb;
            io_wlast = (i == nbeats - 1);
            t = 0;
            while (!io_wready && t < 50) begin @(negedge clock); t++; end
            if (t >= 50) to = 1;
            @(negedge clock);
        end
        io_wvalid = 1'b0; io_wlast = 1'b0;
        io_bready = 1'b1;
        t = 0;
        while (!io_bvalid && t < 50) begin @(negedge clock); t++; end
        if (t >= 50) to = 1;
        wr_bresp = io_bresp; wr_bid = io_bid;
        @(negedge clock);
        io_bready = 1'b0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL write_timeout addr=%h got=timeout want=handshake", addr);
        end
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst,
                           input bit toggle);
        int t;
        int cyc;
        bit done;
        @(negedge clock);
        io_arid = id; io_araddr = addr; io_arlen = len;
        io_arsize = 3'd2; io_arburst = burst; io_arvalid = 1'b1;
        t = 0;
        while (!io_arready && t < 50) begin @(negedge clock); t++; end
        @(negedge clock);
        io_arvalid = 1'b0;
        rd_first = io_rvalid;
        rd_id = io_rid;
        rd_n = 0; cyc = 0; done = 0;
        while (!done && cyc < 100) begin
            io_rready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (io_rvalid && io_rready && rd_n < 16) begin
                rd_data[rd_n] = io_rdata;
                rd_resp[rd_n] = io_rresp;
                rd_last[rd_n] = io_rlast;
                if (io_rlast) done = 1;
                rd_n++;
            end
            @(negedge clock);
            cyc++;
        end
        io_rready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL read_timeout addr=%h got=no_rlast want=rlast", addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks += 10;
        if (io_arready !== 1'b1) begin errors++; $display("FAIL rst_arready got=%b want=1", io_arready); end
        if (io_awready !== 1'b1) begin errors++; $display("FAIL rst_awready got=%b want=1", io_awready); end
        if (io_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b want=0", io_rvalid); end
        if (io_wready !== 1'b0) begin errors++; $display("FAIL rst_wready got=%b want=0", io_wready); end
        if (io_bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got=%b want=0", io_bvalid); end
        if (io_rlast !== 1'b0) begin errors++; $display("FAIL rst_rlast got=%b want=0", io_rlast); end
        if (io_rid !== 4'd0) begin errors++; $display("FAIL rst_rid got=%h want=0", io_rid); end
        if (io_bid !== 4'd0) begin errors++; $display("FAIL rst_bid got=%h want=0", io_bid); end
        if (io_rresp !== 2'b00) begin errors++; $display("FAIL rst_rresp got=%b want=00", io_rresp); end
        if (io_bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp got=%b want=00", io_bresp); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        wq[0] = 32'hDEADBEEF;
        do_write(4'd3, 32'h1000, 8'd0, 2'b01, 1, 4'hF);
        checks += 2;
        if (wr_bresp !== 2'b00) begin errors++; $display("FAIL single_bresp got=%b want=00", wr_bresp); end
        if (wr_bid !== 4'd3) begin errors++; $display("FAIL single_bid got=%h want=3", wr_bid); end
        do_read(4'd5, 32'h1000, 8'd0, 2'b01, 0);
        checks += 6;
        if (rd_first !== 1'b1) begin errors++; $display("FAIL single_rvalid_lat got=%b want=1", rd_first); end
        if (rd_id !== 4'd5) begin errors++; $display("FAIL single_rid got=%h want=5", rd_id); end
        if (rd_n !== 1) begin errors++; $display("FAIL single_beats got=%0d want=1", rd_n); end
        if (rd_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%h want=deadbeef", rd_data[0]); end
        if (rd_last[0] !== 1'b1) begin errors++; $display("FAIL single_rlast got=%b want=1", rd_last[0]); end
        if (rd_resp[0] !== 2'b00) begin errors++; $display("FAIL single_rresp got=%b want=00", rd_resp[0]); end
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) wq[i] = 32'(i + 1);
        do_write(4'd1, 32'h2000, 8'd3, 2'b01, 4, 4'hF);
        checks++;
        if (wr_bresp !== 2'b00) begin errors++; $display("FAIL incr_bresp got=%b want=00", wr_bresp); end
        do_read(4'd2, 32'h2000, 8'd3, 2'b01, 1);
        checks++;
        if (rd_n !== 4) begin errors++; $display("FAIL incr_beats got=%0d want=4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (rd_data[i] !== 32'(i + 1)) begin
                errors++; $display("FAIL incr_rdata%0d got=%h want=%h", i, rd_data[i], i + 1);
            end
            if (rd_last[i] !== (i == 3)) begin
                errors++; $display("FAIL incr_rlast%0d got=%b want=%b", i, rd_last[i], i == 3);
            end
        end
        checks += 2;
        if (io_rvalid !== 1'b0) begin errors++; $display("FAIL incr_rvalid_after got=%b want=0", io_rvalid); end
        if (io_arready !== 1'b1) begin errors++; $display("FAIL incr_arready_after got=%b want=1", io_arready); end
        do_read(4'd2, 32'h2004, 8'd1, 2'b00, 0);
        checks += 2;
        if (rd_data[0] !== 32'd2 || rd_data[1] !== 32'd2) begin
            errors++; $display("FAIL fixed_rdata got=%h,%h want=2,2", rd_data[0], rd_data[1]);
        end
        if (rd_resp[1] !== 2'b00) begin errors++; $display("FAIL fixed_rresp got=%b want=00", rd_resp[1]); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        wq[0] = 32'hA; wq[1] = 32'hB; wq[2] = 32'hC; wq[3] = 32'hD;
        do_write(4'd0, 32'h30, 8'd3, 2'b01, 4, 4'hF);
        exp[0] = 32'hC; exp[1] = 32'hD; exp[2] = 32'hA; exp[3] = 32'hB;
        do_read(4'd0, 32'h38, 8'd3, 2'b10, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== exp[i]) begin
                errors++; $display("FAIL wrap_rdata%0d got=%h want=%h", i, rd_data[i], exp[i]);
            end
        end
        checks++;
        if (rd_resp[0] !== 2'b00) begin errors++; $display("FAIL wrap_rresp got=%b want=00", rd_resp[0]); end
    endtask

    task automatic test_strobe();
        wq[0] = 32'h11223344;
        do_write(4'd0, 32'h400, 8'd0, 2'b01, 1, 4'hF);
        wq[0] = 32'hAABBCCDD;
        do_write(4'd0, 32'h400, 8'd0, 2'b01, 1, 4'b0101);
        do_read(4'd0, 32'h400, 8'd0, 2'b01, 0);
        checks++;
        if (rd_data[0] !== 32'h11BB33DD) begin
            errors++; $display("FAIL strobe_rdata got=%h want=11bb33dd", rd_data[0]);
        end
    endtask

    task automatic test_errors();
        wq[0] = 32'h0; wq[1] = 32'h0;
        do_write(4'd0, 32'h600, 8'd1, 2'b01, 2, 4'hF);
        wq[0] = 32'h77;
        do_write(4'd9, 32'h600, 8'd1, 2'b01, 1, 4'hF);
        checks += 2;
        if (wr_bresp !== 2'b10) begin errors++; $display("FAIL err_wlast_bresp got=%b want=10", wr_bresp); end
        if (wr_bid !== 4'd9) begin errors++; $display("FAIL err_wlast_bid got=%h want=9", wr_bid); end
        do_read(4'd0, 32'h600, 8'd1, 2'b01, 0);
        checks += 3;
        if (rd_data[0] !== 32'h77) begin errors++; $display("FAIL err_word0 got=%h want=77", rd_data[0]); end
        if (rd_data[1] !== 32'h0) begin errors++; $display("FAIL err_word1 got=%h want=0", rd_data[1]); end
        if (rd_resp[0] !== 2'b00) begin errors++; $display("FAIL err_ok_rresp got=%b want=00", rd_resp[0]); end
        do_read(4'd4, 32'h600, 8'd1, 2'b11, 0);
        checks += 4;
        if (rd_n !== 2) begin errors++; $display("FAIL err_rsvd_beats got=%0d want=2", rd_n); end
        if (rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10) begin
            errors++; $display("FAIL err_rsvd_rresp got=%b,%b want=10,10", rd_resp[0], rd_resp[1]);
        end
        if (rd_data[0] !== 32'h77) begin errors++; $display("FAIL err_rsvd_d0 got=%h want=77", rd_data[0]); end
        if (rd_data[1] !== 32'h0) begin errors++; $display("FAIL err_rsvd_d1 got=%h want=0", rd_data[1]); end
    endtask

    task automatic test_concurrent();
        wq[0] = 32'h55;
        do_write(4'd0, 32'h500, 8'd0, 2'b01, 1, 4'hF);
        @(negedge clock);
        io_awid = 4'd6; io_awaddr = 32'h500; io_awlen = 8'd0;
        io_awsize = 3'd2; io_awburst = 2'b01; io_awvalid = 1'b1;
        io_arid = 4'd7; io_araddr = 32'h500; io_arlen = 8'd0;
        io_arsize = 3'd2; io_arburst = 2'b01; io_arvalid = 1'b1;
        @(negedge clock);
        io_awvalid = 1'b0; io_arvalid = 1'b0;
        io_wvalid = 1'b1; io_wdata = 32'h66; io_wstrb = 4'hF; io_wlast = 1'b1;
        io_rready = 1'b1;
        checks += 3;
        if (io_rvalid !== 1'b1) begin errors++; $display("FAIL conc_rvalid got=%b want=1", io_rvalid); end
        if (io_wready !== 1'b1) begin errors++; $display("FAIL conc_wready got=%b want=1", io_wready); end
        if (io_rdata !== 32'h55) begin errors++; $display("FAIL conc_old_rdata got=%h want=55", io_rdata); end
        @(negedge clock);
        io_wvalid = 1'b0; io_wlast = 1'b0; io_rready = 1'b0; io_bready = 1'b1;
        checks += 2;
        if (io_bvalid !== 1'b1) begin errors++; $display("FAIL conc_bvalid got=%b want=1", io_bvalid); end
        if (io_rvalid !== 1'b0) begin errors++; $display("FAIL conc_rdone got=%b want=0", io_rvalid); end
        @(negedge clock);
        io_bready = 1'b0;
        do_read(4'd0, 32'h500, 8'd0, 2'b01, 0);
        checks++;
        if (rd_data[0] !== 32'h66) begin errors++; $display("FAIL conc_new_rdata got=%h want=66", rd_data[0]); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clock);
        io_arid = 4'd1; io_araddr = 32'h2000; io_arlen = 8'd3;
        io_arsize = 3'd2; io_arburst = 2'b01; io_arvalid = 1'b1;
        @(negedge clock);
        io_arvalid = 1'b0;
        checks++;
        if (io_rvalid !== 1'b1) begin errors++; $display("FAIL rstmid_rvalid_pre got=%b want=1", io_rvalid); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks += 2;
        if (io_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got=%b want=0", io_rvalid); end
        if (io_arready !== 1'b1) begin errors++; $display("FAIL rstmid_arready got=%b want=1", io_arready); end
        do_read(4'd0, 32'h1000, 8'd0, 2'b01, 0);
        checks++;
        if (rd_data[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rstmid_mem got=%h want=deadbeef", rd_data[0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        io_arid = '0; io_araddr = '0; io_arlen = '0; io_arsize = '0;
        io_arburst = '0; io_arvalid = 1'b0; io_rready = 1'b0;
        io_awid = '0; io_awaddr = '0; io_awlen = '0; io_awsize = '0;
        io_awburst = '0; io_awvalid = 1'b0;
        io_wid = '0; io_wdata = '0; io_wstrb = '0; io_wlast = 1'b0;
        io_wvalid = 1'b0; io_bready = 1'b0;
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_strobe();
        test_errors();
        test_concurrent();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
